fmult_arbiter: RTL and testbench
================================

FMULT_ARBITER -- requirements
Module: fmult_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one fmult unit (2..8).
REQ-002 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port req_a, input, NREQ*32, operand A per requester; slice i = bits [32*i+31:32*i].
REQ-005 SHALL have port req_b, input, NREQ*32, operand B per requester, sliced as req_a.
REQ-006 SHALL have port req_stb, input, NREQ, requester i has a valid operand pair.
REQ-007 SHALL have port req_ack, output, NREQ, operand pair accepted from requester i.
REQ-008 SHALL have port resp_z, output, 32, product for the currently granted requester.
REQ-009 SHALL have port resp_stb, output, NREQ, resp_z valid for requester i.
REQ-010 SHALL have port resp_ack, input, NREQ, requester i consumed resp_z.
REQ-011 SHALL have ports m_a / m_b, output, 32 each, operands to fmult input_a / input_b.
REQ-012 SHALL have ports m_a_stb / m_b_stb, output, 1 each; m_a_ack / m_b_ack, input, 1 each; fmult operand handshakes.
REQ-013 SHALL have ports m_z, input, 32; m_z_stb, input, 1; m_z_ack, output, 1; fmult result handshake.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 Every handshake SHALL transfer on a rising edge where its stb and ack are both high; either side may hold its signal indefinitely.
REQ-016 SHALL implement states IDLE, ACCEPT, SEND_A, SEND_B, WAIT_Z, RESP.
REQ-017 IDLE: if any req_stb is high, SHALL latch grant g = first set bit searching upward cyclically from last+1 and go to ACCEPT; otherwise stay.
REQ-018 ACCEPT: req_ack[g] SHALL be high; on req_stb[g] & req_ack[g], SHALL capture slice g of req_a/req_b, drop req_ack[g], go to SEND_A.
REQ-019 ACCEPT: if req_stb[g] is low, SHALL return to IDLE with last unchanged (withdrawn request).
REQ-020 SEND_A: m_a_stb=1, m_a=captured A; on m_a_ack SHALL go to SEND_B. SEND_B likewise with m_b, m_b_stb, m_b_ack, then go to WAIT_Z.
REQ-021 WAIT_Z: m_z_ack=1; on m_z_stb SHALL capture m_z into resp_z, drop m_z_ack, go to RESP.
REQ-022 RESP: resp_stb[g]=1; on resp_ack[g] SHALL drop resp_stb[g], set last=g, go to IDLE.
REQ-023 At most one bit of req_ack and one bit of resp_stb SHALL be high in any cycle, always for index g.
REQ-024 Requests arriving while busy SHALL wait; arbitration SHALL only occur in IDLE.
REQ-025 Zero-wait-state overhead: req_stb held high to fmult result SHALL take 2 arbiter cycles (IDLE, ACCEPT) plus fmult latency plus 1 RESP cycle minimum.
REQ-026 Round-robin: with all NREQ requesters continuously requesting, each SHALL be served exactly once per NREQ transactions.
REQ-027 Pointer last SHALL wrap from NREQ-1 to 0; grant search SHALL be width NREQ, no out-of-range index.
REQ-028 Operand/result values SHALL pass unmodified; block performs no floating-point arithmetic.

Reset
REQ-029 On rst high: state=IDLE, last=NREQ-1 (requester 0 wins first), req_ack=0, resp_stb=0, m_a_stb=0, m_b_stb=0, m_z_ack=0, resp_z=0, busy=0.
REQ-030 Reset mid-transaction SHALL abandon the transaction without response; fmult SHALL share the same reset so no stale result returns.

Structure
REQ-031 State encoding and NREQ default SHALL live in shared package fmult_arb_pkg.
REQ-032 Grant search SHALL be a sub-module rr_pick (combinational: request vector, last pointer -> grant index, any).

Verification
REQ-033 Req 0: A=0x40000000, B=0x40400000 -> resp_stb[0], resp_z=0x40C00000; req_ack[0] exactly one cycle.
REQ-034 Req 0 and 2 simultaneously from reset (0x3FC00000*0x40800000, 0xBF800000*0x3F000000) -> req 0 served first (0x40C00000), then req 2 (0xBF000000).
REQ-035 All 4 requesting continuously for 12 transactions -> grant order 0,1,2,3 repeated three times.
REQ-036 resp_ack[1] held low 20 cycles -> resp_stb[1] and resp_z stable, m_a_stb low, no new req_ack.
REQ-037 rst asserted during WAIT_Z -> all outputs zero next edge; after release req 0 transaction completes correctly.
REQ-038 req_stb[3] dropped while in ACCEPT -> return to IDLE, no m_a_stb, next grant still searches from last+1.

Source files
------------

// File: rtl/fmult_arb_pkg.sv
// Shared definitions for the fmult arbiter: controller state encoding,
// operand width and default requester count.
package fmult_arb_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int DATA_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT_Z,
    ST_RESP
  } state_e;

endpackage

// File: rtl/fmult_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit found by scanning
// upward from last_i+1, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [$clog2(NREQ)-1:0] grant_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    grant_o = '0;
    cand    = '0;
    any_o   = |req_i;
    // Scanning from the farthest candidate down lets the nearest hit win.
    for (int i = NREQ; i >= 1; i--) begin
      cand = {1'b0, last_i} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (req_i[cand[IW-1:0]]) begin
        grant_o = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fmult_arbiter.sv
// Shares one fmult unit among NREQ requesters: round-robin grant in IDLE,
// then operand/result handshakes are forwarded untouched for the granted one.
module fmult_arbiter
  import fmult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_stb,
  output logic [NREQ-1:0]        req_ack,
  output logic [DATA_W-1:0]      resp_z,
  output logic [NREQ-1:0]        resp_stb,
  input  logic [NREQ-1:0]        resp_ack,
  output logic [DATA_W-1:0]      m_a,
  output logic [DATA_W-1:0]      m_b,
  output logic                   m_a_stb,
  output logic                   m_b_stb,
  input  logic                   m_a_ack,
  input  logic                   m_b_ack,
  input  logic [DATA_W-1:0]      m_z,
  input  logic                   m_z_stb,
  output logic                   m_z_ack,
  output logic                   busy
);

  localparam int IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [IW-1:0]     pick;
  logic              pick_any;

  logic [DATA_W-1:0] slice_a [NREQ];
  logic [DATA_W-1:0] slice_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice_a[i] = req_a[DATA_W*i +: DATA_W];
    assign slice_b[i] = req_b[DATA_W*i +: DATA_W];
  end

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i  (req_stb),
    .last_i (last_q),
    .grant_o(pick),
    .any_o  (pick_any)
  );

  // last resets to NREQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ-1);
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    req_ack  = '0;
    resp_stb = '0;
    m_a_stb  = 1'b0;
    m_b_stb  = 1'b0;
    m_z_ack  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        req_ack[grant_q] = 1'b1;
        // A requester that withdrew loses the slot; last is left untouched.
        if (req_stb[grant_q]) begin
          a_d     = slice_a[grant_q];
          b_d     = slice_b[grant_q];
          state_d = ST_SEND_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_A: begin
        m_a_stb = 1'b1;
        if (m_a_ack) state_d = ST_SEND_B;
      end
      ST_SEND_B: begin
        m_b_stb = 1'b1;
        if (m_b_ack) state_d = ST_WAIT_Z;
      end
      ST_WAIT_Z: begin
        m_z_ack = 1'b1;
        if (m_z_stb) begin
          z_d     = m_z;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_stb[grant_q] = 1'b1;
        if (resp_ack[grant_q]) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_a    = a_q;
  assign m_b    = b_q;
  assign resp_z = z_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fmult_arbiter.sv
// Bench for fmult_arbiter: requester agents, a behavioural fmult and a
// round-robin/result reference model computed from the arbitration rules.
module tb_fmult_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]    req_stb, req_ack, resp_stb, resp_ack;
  logic [31:0]     resp_z, m_a, m_b, m_z;
  logic            m_a_stb, m_b_stb, m_a_ack, m_b_ack, m_z_stb, m_z_ack, busy;

  int checks = 0;
  int errors = 0;

  fmult_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack),
    .m_a(m_a), .m_b(m_b), .m_a_stb(m_a_stb), .m_b_stb(m_b_stb),
    .m_a_ack(m_a_ack), .m_b_ack(m_b_ack),
    .m_z(m_z), .m_z_stb(m_z_stb), .m_z_ack(m_z_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- single-precision helpers (normal numbers only) ----------
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return $bitstoreal({x[31], 63'd0});
    e = {3'd0, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) * sp2r(b));
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    e = 8'($urandom_range(110, 140));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Round-robin rule: first requester in mask after 'last', wrapping at N.
  function automatic int rr_expect(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // ---------------- behavioural fmult (shares rst) ---------------------------
  int          fm_st, fm_dly;
  logic        fm_fast;
  logic [31:0] fm_a, fm_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fm_st <= 0; fm_dly <= 0; fm_a <= '0; fm_b <= '0;
      m_a_ack <= 1'b0; m_b_ack <= 1'b0; m_z_stb <= 1'b0; m_z <= '0;
    end else begin
      case (fm_st)
        0: if (m_a_stb && m_a_ack) begin
             fm_a <= m_a; m_a_ack <= 1'b0; m_b_ack <= fm_fast; fm_st <= 1;
           end else m_a_ack <= fm_fast | 1'($urandom_range(0, 1));
        1: if (m_b_stb && m_b_ack) begin
             fm_b <= m_b; m_b_ack <= 1'b0; fm_st <= 2;
             fm_dly <= fm_fast ? 0 : int'($urandom_range(0, 3));
           end else m_b_ack <= fm_fast | 1'($urandom_range(0, 1));
        2: if (fm_dly == 0) begin
             m_z <= fmul(fm_a, fm_b); m_z_stb <= 1'b1; fm_st <= 3;
           end else fm_dly <= fm_dly - 1;
        3: if (m_z_ack) begin
             m_z_stb <= 1'b0; m_z <= $urandom; m_a_ack <= fm_fast; fm_st <= 0;
           end
        default: fm_st <= 0;
      endcase
    end
  end

  // ---------------- requester agents + scoreboard ----------------------------
  logic        agent_en = 1'b0;
  logic [31:0] op_a [N][8];
  logic [31:0] op_b [N][8];
  int          op_n [N];
  int          op_k [N];
  int          stall [N];
  logic [N-1:0] acc_pend;
  logic        exp_valid;
  int          exp_idx;
  logic [31:0] exp_a, exp_b, exp_z;
  int          grant_log [$];
  logic [31:0] resp_log [$];
  int          resp_cnt = 0;
  int          model_last;

  initial begin
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        req_stb = '0; resp_ack = '0; acc_pend = '0; exp_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
          op_n[i] = 0; op_k[i] = 0; stall[i] = 0;
        end
      end else if (agent_en) begin
        for (int i = 0; i < N; i++) begin
          if (acc_pend[i]) begin
            acc_pend[i] = 1'b0;
            op_k[i]++;
            if (op_k[i] < op_n[i]) begin
              req_a[32*i +: 32] = op_a[i][op_k[i]];
              req_b[32*i +: 32] = op_b[i][op_k[i]];
            end else req_stb[i] = 1'b0;
          end else if (!req_stb[i] && op_k[i] < op_n[i]) begin
            req_a[32*i +: 32] = op_a[i][op_k[i]];
            req_b[32*i +: 32] = op_b[i][op_k[i]];
            req_stb[i] = 1'b1;
          end
          if (resp_stb[i] && stall[i] > 0) begin
            resp_ack[i] = 1'b0;
            stall[i]--;
          end else resp_ack[i] = 1'($urandom_range(0, 1));
          if (req_stb[i] && req_ack[i]) begin
            acc_pend[i] = 1'b1;
            grant_log.push_back(i);
            exp_valid = 1'b1; exp_idx = i;
            exp_a = op_a[i][op_k[i]]; exp_b = op_b[i][op_k[i]];
            exp_z = fmul(exp_a, exp_b);
          end
          if (resp_stb[i] && resp_ack[i]) begin
            checks++;
            if (!exp_valid || exp_idx != i || resp_z !== exp_z) begin
              errors++;
              $display("FAIL scoreboard: got requester %0d resp_z=%h, required requester %0d resp_z=%h (pending=%0b)",
                       i, resp_z, exp_idx, exp_z, exp_valid);
            end
            resp_log.push_back(resp_z);
            resp_cnt++;
            exp_valid = 1'b0;
          end
        end
      end
    end
  end

  // Cycle-level invariants: one-hot handshakes and operand pass-through.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (!$onehot0(req_ack) || !$onehot0(resp_stb) ||
            ((req_ack != '0 || resp_stb != '0) && !busy)) begin
          errors++;
          $display("FAIL invariant: req_ack=%b resp_stb=%b busy=%b", req_ack, resp_stb, busy);
        end
        if (agent_en && exp_valid && (m_a_stb || m_b_stb)) begin
          checks++;
          if ((m_a_stb && m_a !== exp_a) || (m_b_stb && m_b !== exp_b)) begin
            errors++;
            $display("FAIL operand_pass: m_a=%h m_b=%h, required %h %h", m_a, m_b, exp_a, exp_b);
          end
        end
      end
    end
  end

  // ---------------- helpers --------------------------------------------------
  task automatic clear_logs();
    grant_log.delete(); resp_log.delete(); resp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      op_n[i] = 0; op_k[i] = 0; stall[i] = 0;
    end
  endtask

  task automatic set_op(input int i, input int k, input logic [31:0] a, input logic [31:0] b);
    op_a[i][k] = a; op_b[i][k] = b; op_n[i] = k + 1;
  endtask

  task automatic do_reset();
    agent_en = 1'b0; rst = 1'b1;
    req_stb = '0; resp_ack = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    model_last = N - 1;
    @(negedge clk);
  endtask

  task automatic wait_resp(input int target, input string name);
    int cyc = 0;
    while (resp_cnt < target && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (resp_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: %0d responses, required %0d", name, resp_cnt, target);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic int glog(input int k);
    return (grant_log.size() > k) ? grant_log[k] : -1;
  endfunction

  function automatic logic [31:0] rlog(input int k);
    return (resp_log.size() > k) ? resp_log[k] : 32'hxxxxxxxx;
  endfunction

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks += 7;
    if (req_ack !== '0)  begin errors++; $display("FAIL reset_req_ack: %b, required 0", req_ack); end
    if (resp_stb !== '0) begin errors++; $display("FAIL reset_resp_stb: %b, required 0", resp_stb); end
    if (m_a_stb !== 1'b0) begin errors++; $display("FAIL reset_m_a_stb: %b, required 0", m_a_stb); end
    if (m_b_stb !== 1'b0) begin errors++; $display("FAIL reset_m_b_stb: %b, required 0", m_b_stb); end
    if (m_z_ack !== 1'b0) begin errors++; $display("FAIL reset_m_z_ack: %b, required 0", m_z_ack); end
    if (resp_z !== '0)   begin errors++; $display("FAIL reset_resp_z: %h, required 0", resp_z); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
  endtask

  // Zero-wait fmult: IDLE, ACCEPT, SEND_A, SEND_B, two fmult cycles -> RESP after 6 edges.
  task automatic test_single();
    int cyc = 0, ack_cnt = 0;
    logic ack_seen = 1'b0;
    fm_fast = 1'b1;
    @(negedge clk);
    req_a[31:0] = 32'h40000000; req_b[31:0] = 32'h40400000; req_stb[0] = 1'b1;
    while (!resp_stb[0] && cyc < 50) begin
      @(negedge clk); cyc++;
      if (ack_seen) req_stb[0] = 1'b0;
      if (req_ack[0]) begin ack_cnt++; ack_seen = 1'b1; end
      if (m_a_stb) begin
        checks++;
        if (m_a !== 32'h40000000) begin errors++; $display("FAIL single_m_a: %h, required 40000000", m_a); end
      end
      if (m_b_stb) begin
        checks++;
        if (m_b !== 32'h40400000) begin errors++; $display("FAIL single_m_b: %h, required 40400000", m_b); end
      end
    end
    checks += 4;
    if (cyc != 6) begin errors++; $display("FAIL single_latency: %0d cycles, required 6", cyc); end
    if (ack_cnt != 1) begin errors++; $display("FAIL single_ack_cycles: %0d, required 1", ack_cnt); end
    if (resp_stb !== 4'b0001) begin errors++; $display("FAIL single_resp_stb: %b, required 0001", resp_stb); end
    if (resp_z !== 32'h40C00000) begin errors++; $display("FAIL single_resp_z: %h, required 40c00000", resp_z); end
    resp_ack[0] = 1'b1;
    @(negedge clk);
    resp_ack[0] = 1'b0;
    checks++;
    if (resp_stb !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release: resp_stb=%b busy=%b, required 0 0", resp_stb, busy);
    end
    fm_fast = 1'b0;
    model_last = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_op(0, 0, 32'h3FC00000, 32'h40800000);
    set_op(2, 0, 32'hBF800000, 32'h3F000000);
    agent_en = 1'b1;
    wait_resp(2, "simul");
    checks += 4;
    if (glog(0) != 0) begin errors++; $display("FAIL simul_first_grant: %0d, required 0", glog(0)); end
    if (glog(1) != 2) begin errors++; $display("FAIL simul_second_grant: %0d, required 2", glog(1)); end
    if (rlog(0) !== 32'h40C00000) begin errors++; $display("FAIL simul_z0: %h, required 40c00000", rlog(0)); end
    if (rlog(1) !== 32'hBF000000) begin errors++; $display("FAIL simul_z2: %h, required bf000000", rlog(1)); end
    model_last = 2;
  endtask

  // Runs a contended burst: 'cnt' operations from each requester in 'mask',
  // all held continuously, and checks the grant order against the model.
  task automatic run_burst(input logic [N-1:0] mask, input int cnt, input string name);
    int rem [N];
    int exp_order [$];
    int total = 0, last, g;
    logic [N-1:0] live;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      rem[i] = mask[i] ? cnt : 0;
      for (int k = 0; k < rem[i]; k++) set_op(i, k, rand_op(), rand_op());
      total += rem[i];
    end
    last = model_last;
    for (int t = 0; t < total; t++) begin
      for (int i = 0; i < N; i++) live[i] = (rem[i] > 0);
      g = rr_expect(live, last);
      exp_order.push_back(g);
      rem[g]--; last = g;
    end
    agent_en = 1'b1;
    wait_resp(total, name);
    for (int t = 0; t < total; t++) begin
      checks++;
      if (glog(t) != exp_order[t]) begin
        errors++; $display("FAIL %s_grant[%0d]: %0d, required %0d", name, t, glog(t), exp_order[t]);
      end
    end
    model_last = last;
  endtask

  task automatic test_round_robin();
    do_reset();
    run_burst(4'b1111, 3, "rr");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      run_burst(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(1, 3)), "rand");
    end
  endtask

  task automatic test_resp_stall();
    int cyc = 0;
    logic [31:0] z0;
    clear_logs();
    set_op(1, 0, rand_op(), rand_op());
    stall[1] = 20;
    agent_en = 1'b1;
    while (!resp_stb[1] && cyc < 500) begin @(negedge clk); cyc++; end
    checks++;
    if (!resp_stb[1]) begin errors++; $display("FAIL stall_resp_seen: resp_stb=%b, required bit 1", resp_stb); end
    set_op(3, 0, rand_op(), rand_op());
    z0 = resp_z;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      checks++;
      if (resp_stb !== 4'b0010 || resp_z !== z0 || m_a_stb !== 1'b0 || req_ack !== '0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: resp_stb=%b resp_z=%h m_a_stb=%b req_ack=%b, required 0010 %h 0 0000",
                 c, resp_stb, resp_z, m_a_stb, req_ack, z0);
      end
    end
    wait_resp(2, "stall");
    checks += 2;
    if (glog(0) != 1) begin errors++; $display("FAIL stall_grant0: %0d, required 1", glog(0)); end
    if (glog(1) != 3) begin errors++; $display("FAIL stall_grant1: %0d, required 3", glog(1)); end
    model_last = 3;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    logic [31:0] a, b;
    clear_logs();
    fm_fast = 1'b1;
    set_op(0, 0, rand_op(), rand_op());
    agent_en = 1'b1;
    while (!m_z_ack && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (!m_z_ack) begin errors++; $display("FAIL rstmid_wait_z: m_z_ack=%b, required 1", m_z_ack); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ack !== '0 || resp_stb !== '0 || m_a_stb !== 1'b0 || m_b_stb !== 1'b0 ||
        m_z_ack !== 1'b0 || resp_z !== '0 || busy !== 1'b0 || m_a !== '0 || m_b !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: req_ack=%b resp_stb=%b m_a_stb=%b m_b_stb=%b m_z_ack=%b resp_z=%h busy=%b m_a=%h m_b=%h, required all 0",
               req_ack, resp_stb, m_a_stb, m_b_stb, m_z_ack, resp_z, busy, m_a, m_b);
    end
    @(negedge clk);
    rst = 1'b0;
    model_last = N - 1;
    @(negedge clk);
    clear_logs();
    a = 32'h40000000; b = 32'h40400000;
    set_op(0, 0, a, b);
    wait_resp(1, "rstmid");
    checks += 2;
    if (glog(0) != 0) begin errors++; $display("FAIL rstmid_grant: %0d, required 0", glog(0)); end
    if (rlog(0) !== 32'h40C00000) begin errors++; $display("FAIL rstmid_z: %h, required 40c00000", rlog(0)); end
    fm_fast = 1'b0;
    model_last = 0;
  endtask

  task automatic test_withdraw();
    int cyc = 0;
    int g0;
    agent_en = 1'b0;
    @(negedge clk);
    req_a[127:96] = rand_op(); req_stb[3] = 1'b1;
    while (!req_ack[3] && cyc < 50) begin @(negedge clk); cyc++; end
    checks++;
    if (!req_ack[3]) begin errors++; $display("FAIL withdraw_accept: req_ack=%b, required bit 3", req_ack); end
    req_stb[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m_a_stb !== 1'b0 || req_ack !== '0) begin
        errors++;
        $display("FAIL withdraw_idle[%0d]: busy=%b m_a_stb=%b req_ack=%b, required 0 0 0000",
                 c, busy, m_a_stb, req_ack);
      end
    end
    clear_logs();
    set_op(0, 0, rand_op(), rand_op());
    set_op(3, 0, rand_op(), rand_op());
    agent_en = 1'b1;
    wait_resp(2, "withdraw");
    g0 = rr_expect(4'b1001, model_last);
    checks += 2;
    if (glog(0) != g0) begin errors++; $display("FAIL withdraw_next_grant: %0d, required %0d", glog(0), g0); end
    if (glog(1) != (g0 == 3 ? 0 : 3)) begin
      errors++; $display("FAIL withdraw_second_grant: %0d, required %0d", glog(1), (g0 == 3 ? 0 : 3));
    end
  endtask

  initial begin
    rst = 1'b1; fm_fast = 1'b0;
    req_stb = '0; resp_ack = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_resp_stall();
    test_random();
    test_reset_mid();
    test_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
